// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single outstanding memory request,
// IF/ID pipeline register, one-entry skid buffer for decode stalls and a
// deferred (delay-slot preserving) redirect.
// Optional feature: define FETCH_ALIGN_CHECK_EN to suppress fetches from
// misaligned PCs and report them on adel_D instead.
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        npc_sel,
    input  logic [31:0] NextPC_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC4_D,
    output logic        valid_D
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        adel_D
`endif
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_armed;      // low for the first cycle after reset release
    logic [31:0] r_pc;
    logic        r_redir_vld;
    logic [31:0] r_redir_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc4;

    logic        w_misal;
    logic        w_req;
    logic        w_ack;
    logic        w_fire;
    logic        w_sample;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_adv;
    logic        w_load_f;
    logic        w_load_skid;
    logic        w_bubble;
    logic        w_capture;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misal = (r_pc[1:0] != 2'b00);
`else
    assign w_misal = 1'b0;
`endif

    // A misaligned PC completes without touching memory; otherwise only an
    // ack for our own outstanding request counts.
    assign w_req      = (r_state == S_REQ) && r_armed && !w_misal;
    assign w_ack      = w_req && imem_ack;
    assign w_fire     = w_ack || ((r_state == S_REQ) && r_armed && w_misal);
    assign w_sample   = npc_sel && !stall_D;
    assign w_pc_plus4 = r_pc + 32'd4;
    // A redirect seen this cycle wins over an older pending one.
    assign w_next_pc  = w_sample    ? NextPC_in  :
                        r_redir_vld ? r_redir_pc : w_pc_plus4;

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign PC_F      = r_pc;

    // Next-state and per-cycle action decode.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_load_f    = 1'b0;
        w_load_skid = 1'b0;
        w_bubble    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_fire && !stall_D) begin
                    w_load_f = 1'b1;
                    w_adv    = 1'b1;
                end else if (w_ack && stall_D) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (!w_fire && !stall_D) begin
                    w_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (!stall_D) begin
                    w_load_skid = 1'b1;
                    w_adv       = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // State register; arming delay discards a stale ack right after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_REQ;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
        end
    end

    // PC advance and pending-redirect bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_redir_vld <= 1'b0;
            r_redir_pc  <= 32'h0;
        end else if (w_adv) begin
            r_pc        <= w_next_pc;
            r_redir_vld <= 1'b0;
        end else if (w_sample) begin
            r_redir_vld <= 1'b1;
            r_redir_pc  <= NextPC_in;
        end
    end

    // Skid buffer holds a fetch that completed while decode was stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_instr <= 32'h0;
            r_skid_pc4   <= 32'h0;
        end else if (w_capture) begin
            r_skid_instr <= imem_rdata;
            r_skid_pc4   <= w_pc_plus4;
        end
    end

    // IF/ID register: fresh fetch, skid replay, or bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instr_D <= 32'h0;
            PC4_D   <= 32'h0;
            valid_D <= 1'b0;
        end else if (w_load_f) begin
            Instr_D <= w_misal ? 32'h0 : imem_rdata;
            PC4_D   <= w_pc_plus4;
            valid_D <= 1'b1;
        end else if (w_load_skid) begin
            Instr_D <= r_skid_instr;
            PC4_D   <= r_skid_pc4;
            valid_D <= 1'b1;
        end else if (w_bubble) begin
            valid_D <= 1'b0;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned-fetch flag travels with the IF/ID entry it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adel_D <= 1'b0;
        end else if (w_load_f) begin
            adel_D <= w_misal;
        end else if (w_load_skid || w_bubble) begin
            adel_D <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table for fetch_stage plus hand-written
// sequences for alignment handling and reset in the middle of a fetch.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_D;
    logic        npc_sel;
    logic [31:0] NextPC_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PC4_D;
    logic        valid_D;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        adel_D;
`endif

    int total;
    int bad;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall_D    (stall_D),
        .npc_sel    (npc_sel),
        .NextPC_in  (NextPC_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .PC_F       (PC_F),
        .Instr_D    (Instr_D),
        .PC4_D      (PC4_D),
        .valid_D    (valid_D)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .adel_D     (adel_D)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        npc;
        logic [31:0] npc_pc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ns, input logic [31:0] np,
                         input logic ak, input logic [31:0] rd);
        stall_D    = st;
        npc_sel    = ns;
        NextPC_in  = np;
        imem_ack   = ak;
        imem_rdata = rd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        //            stall npc   npc_pc        ack   rdata          req   addr          pc            instr         pc4           valid
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hBAD0BAD0, 1'b0, 32'h00003000, 32'h00003000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h11113000, 1'b1, 32'h00003000, 32'h00003004, 32'h11113000, 32'h00003004, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h11113004, 1'b1, 32'h00003004, 32'h00003004, 32'h11113000, 32'h00003004, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00003004, 32'h00003004, 32'h11113000, 32'h00003004, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00003004, 32'h00003004, 32'h11113000, 32'h00003004, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00003004, 32'h00003008, 32'h11113004, 32'h00003008, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h11113008, 1'b1, 32'h00003008, 32'h0000300C, 32'h11113008, 32'h0000300C, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h00003100, 1'b0, 32'h0,        1'b1, 32'h0000300C, 32'h0000300C, 32'h11113008, 32'h0000300C, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1111300C, 1'b1, 32'h0000300C, 32'h00003100, 32'h1111300C, 32'h00003010, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h11113100, 1'b1, 32'h00003100, 32'h00003104, 32'h11113100, 32'h00003104, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h00003100, 1'b0, 32'h0,        1'b1, 32'h00003104, 32'h00003104, 32'h11113100, 32'h00003104, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h00003200, 1'b0, 32'h0,        1'b1, 32'h00003104, 32'h00003104, 32'h11113100, 32'h00003104, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h11113104, 1'b1, 32'h00003104, 32'h00003200, 32'h11113104, 32'h00003108, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 32'h00003300, 1'b1, 32'h11113200, 1'b1, 32'h00003200, 32'h00003300, 32'h11113200, 32'h00003204, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 32'h00003400, 1'b0, 32'h0,        1'b1, 32'h00003300, 32'h00003300, 32'h11113200, 32'h00003204, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h11113300, 1'b1, 32'h00003300, 32'h00003304, 32'h11113300, 32'h00003304, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h11113304, 1'b1, 32'h00003304, 32'hFFFFFFFC, 32'h11113304, 32'h00003308, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h2222FFFC, 1'b1, 32'hFFFFFFFC, 32'h00000000, 32'h2222FFFC, 32'h00000000, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h22220000, 1'b1, 32'h00000000, 32'h00000004, 32'h22220000, 32'h00000004, 1'b1};

        // reset state
        #12;
        chk("rst_pc",    PC_F,              32'h00003000);
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_instr", Instr_D,           32'h0);
        chk("rst_pc4",   PC4_D,             32'h0);
        chk("rst_valid", {31'h0, valid_D},  32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_adel",  {31'h0, adel_D},   32'h0);
`endif

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].npc, vecs[i].npc_pc, vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d_req", i),  {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr,         vecs[i].e_addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i),    PC_F,             vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), Instr_D,          vecs[i].e_instr);
            chk($sformatf("v%0d_pc4", i),   PC4_D,            vecs[i].e_pc4);
            chk($sformatf("v%0d_valid", i), {31'h0, valid_D}, {31'h0, vecs[i].e_valid});
`ifdef FETCH_ALIGN_CHECK_EN
            chk($sformatf("v%0d_adel", i),  {31'h0, adel_D},  32'h0);
`endif
            @(negedge clk);
        end

        // redirect to a misaligned target, taken in the same cycle as an ack
        drive(1'b0, 1'b1, 32'h00003102, 1'b1, 32'h22220004);
        @(posedge clk);
        #1;
        chk("mis_pc", PC_F, 32'h00003102);
        @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("mis_noreq", {31'h0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        chk("mis_valid", {31'h0, valid_D}, 32'h1);
        chk("mis_adel",  {31'h0, adel_D},  32'h1);
        chk("mis_instr", Instr_D,          32'h0);
        chk("mis_pc4",   PC4_D,            32'h00003106);
`else
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h33333102);
        #1;
        chk("mis_req",  {31'h0, imem_req}, 32'h1);
        chk("mis_addr", imem_addr,         32'h00003102);
        @(posedge clk);
        #1;
        chk("mis_valid", {31'h0, valid_D}, 32'h1);
        chk("mis_instr", Instr_D,          32'h33333102);
        chk("mis_pc4",   PC4_D,            32'h00003106);
`endif
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("mis_next_req",  {31'h0, imem_req}, 32'h1);
        chk("mis_next_addr", imem_addr,         32'h00003106);

        // reset asserted mid-cycle while a request is outstanding
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_pc",    PC_F,              32'h00003000);
        chk("mid_rst_req",   {31'h0, imem_req}, 32'h0);
        chk("mid_rst_valid", {31'h0, valid_D},  32'h0);
        chk("mid_rst_instr", Instr_D,           32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBADBAD00);
        @(posedge clk);
        #1;
        chk("stale_valid", {31'h0, valid_D}, 32'h0);
        chk("stale_pc",    PC_F,             32'h00003000);
        chk("stale_instr", Instr_D,          32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h44443000);
        #1;
        chk("post_rst_req",  {31'h0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr,         32'h00003000);
        @(posedge clk);
        #1;
        chk("post_rst_pc",    PC_F,             32'h00003004);
        chk("post_rst_instr", Instr_D,          32'h44443000);
        chk("post_rst_valid", {31'h0, valid_D}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have the ports below; clk, reset first; widths in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 resets all state immediately.
REQ-004 stall_D  input  1  decode stall; 1 freezes PC and the IF/ID register.
REQ-005 npc_sel  input  1  1 = decode requests a control transfer to NextPC_in.
REQ-006 NextPC_in  input  32  transfer target from the next-PC unit.
REQ-007 imem_req  output  1  instruction fetch request, held until acknowledged.
REQ-008 imem_addr  output  32  fetch address, equal to PC_F.
REQ-009 imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-010 imem_ack  input  1  one-cycle completion pulse for the outstanding request.
REQ-011 PC_F  output  32  current fetch PC.
REQ-012 Instr_D  output  32  IF/ID instruction.
REQ-013 PC4_D  output  32  IF/ID address of the instruction plus 4.
REQ-014 valid_D  output  1  1 = Instr_D holds a real instruction; 0 = bubble.
REQ-015 adel_D  output  1  misaligned-fetch flag (present only with FETCH_ALIGN_CHECK_EN).

Function
REQ-016 The FSM SHALL have exactly two states, REQ and HOLD; REQ is entered on reset release.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal PC_F.
- ack=1 with stall_D=0: load Instr_D=imem_rdata, PC4_D=PC_F+4 and valid_D=1; PC_F <= next PC; stay in REQ.
- ack=1 with stall_D=1: capture imem_rdata and PC_F+4 in a skid buffer; go to HOLD.
- ack=0 with stall_D=0: load a bubble (valid_D=0; Instr_D and PC4_D keep their values).
- ack=0 with stall_D=1: hold all state.
REQ-018 In HOLD, imem_req SHALL be 0; when stall_D=0, load IF/ID from the skid buffer with valid_D=1, advance PC_F and return to REQ.
REQ-019 Next PC SHALL be the pending redirect target if one exists (then clear it), otherwise PC_F+4; the add is modulo 2^32 (0xFFFFFFFC+4=0x00000000).
REQ-020 npc_sel SHALL be sampled only when stall_D=0; when sampled, NextPC_in is latched as the pending redirect, and a later redirect overwrites an earlier one.
REQ-021 A redirect sampled in the same cycle as a PC advance SHALL be used for that advance directly, so no extra cycle is spent.
REQ-022 Because the redirect is taken after the in-flight fetch, the fetch in flight when decode redirects is the branch delay slot and SHALL be delivered, never squashed.
REQ-023 At most one fetch SHALL be outstanding; imem_addr SHALL NOT change while imem_req=1 and ack is pending.

Reset
REQ-024 While reset=0: PC_F=0x00003000, imem_req=0, Instr_D=0, PC4_D=0, valid_D=0, adel_D=0, pending redirect cleared, skid buffer cleared, state=REQ.
REQ-025 A reset mid-fetch SHALL abandon the outstanding request; an imem_ack arriving in the first cycle after reset release SHALL be ignored.

Configuration
REQ-026 With FETCH_ALIGN_CHECK_EN defined and PC_F[1:0]!=0, no request SHALL be issued; the next non-stalled cycle SHALL load valid_D=1, Instr_D=0 (nop) and adel_D=1, and PC_F SHALL advance per REQ-019.
REQ-027 Without FETCH_ALIGN_CHECK_EN: the adel_D port is absent, and PC_F[1:0] is ignored (the address is issued as-is).

Verification
REQ-028 Release reset, always-ack memory, stall_D=0 -> imem_addr 0x3000, 0x3004, 0x3008 on successive cycles; PC4_D 0x3004, 0x3008.
REQ-029 Ack at 0x3004 with stall_D=1 for 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; then stall_D=0 -> Instr_D = word from 0x3004, PC4_D=0x3008.
REQ-030 npc_sel=1 with NextPC_in=0x3100 while fetch of 0x3008 is pending with 2-cycle ack -> 0x3008 delivered (delay slot), next imem_addr 0x3100.
REQ-031 Two redirects (0x3100, then 0x3200) before the ack -> next imem_addr 0x3200.
REQ-032 reset pulled low while imem_req=1 -> PC_F=0x3000 and valid_D=0 immediately; a stale ack in the first cycle after release is discarded.
REQ-033 FETCH_ALIGN_CHECK_EN defined, redirect to 0x3102 -> no request at 0x3102; valid_D=1, adel_D=1, Instr_D=0; next imem_addr 0x3106.
